// File: rtl/fb_write_arbiter_if.sv
// Bus bundle between the sync/address generator, the processor write requester
// and the frame-buffer RAM port, as seen by fb_write_arbiter.
interface fb_write_arbiter_if #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              iBLANK_n;
  logic              iVS;
  logic [ADDR_W-1:0] iSCAN_ADDR;
  logic              iWR_VALID;
  logic [ADDR_W-1:0] iWR_ADDR;
  logic [DATA_W-1:0] iWR_DATA;
  logic              oWR_READY;
  logic [ADDR_W-1:0] oRAM_ADDR;
  logic [DATA_W-1:0] oRAM_WDATA;
  logic              oRAM_WE;
  logic [LVL_W-1:0]  oFIFO_LEVEL;
  logic [15:0]       oSTALL_CNT;

  modport slave (
    input  iBLANK_n, iVS, iSCAN_ADDR, iWR_VALID, iWR_ADDR, iWR_DATA,
    output oWR_READY, oRAM_ADDR, oRAM_WDATA, oRAM_WE, oFIFO_LEVEL, oSTALL_CNT
  );

  modport master (
    output iBLANK_n, iVS, iSCAN_ADDR, iWR_VALID, iWR_ADDR, iWR_DATA,
    input  oWR_READY, oRAM_ADDR, oRAM_WDATA, oRAM_WE, oFIFO_LEVEL, oSTALL_CNT
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Frame-buffer port arbiter: scan-out owns the RAM during active video, buffered
// processor writes drain during blanking. Optional stall counter: FB_ARB_STALL_CNT_EN.
module fb_write_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic              iVGA_CLK,
  input logic              iRST,
  fb_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] SCAN  = 2'd0;
  localparam logic [1:0] GUARD = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [LVL_W-1:0] LVL_ZERO  = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] LVL_ONE   = {{(LVL_W-1){1'b0}}, 1'b1};
  localparam logic [LVL_W-1:0] LVL_DEPTH = LVL_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_r;
  logic [1:0]        state_next_s;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [LVL_W-1:0]  level_next_s;
  logic              ready_r;
  logic              push_s;
  logic              pop_s;
  logic [ADDR_W-1:0] mem_addr_r [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data_r [FIFO_DEPTH];
  logic [ADDR_W-1:0] ram_addr_r;
  logic [DATA_W-1:0] ram_wdata_r;
  logic              ram_we_r;

  // Handshake qualification, FIFO level update and FSM next state
  always_comb begin
    push_s       = bus.iWR_VALID & ready_r;
    pop_s        = (state_r == DRAIN) & ~bus.iBLANK_n & (level_r != LVL_ZERO);
    level_next_s = level_r;
    if (push_s && !pop_s) begin
      level_next_s = level_r + LVL_ONE;
    end else if (pop_s && !push_s) begin
      level_next_s = level_r - LVL_ONE;
    end else begin
      level_next_s = level_r;
    end

    state_next_s = state_r;
    case (state_r)
      SCAN:    state_next_s = bus.iBLANK_n ? SCAN : GUARD;
      GUARD:   state_next_s = bus.iBLANK_n ? SCAN : DRAIN;
      DRAIN:   state_next_s = bus.iBLANK_n ? SCAN : DRAIN;
      default: state_next_s = SCAN;
    endcase
  end

  // FSM state, FIFO pointers, level and registered ready
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      state_r  <= SCAN;
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
      ready_r  <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      wr_ptr_r <= push_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
      rd_ptr_r <= pop_s ? rd_ptr_r + PTR_ONE : rd_ptr_r;
      level_r  <= level_next_s;
      ready_r  <= (level_next_s < LVL_DEPTH);
    end
  end

  // FIFO storage; entries are only read after being written, so no reset
  always_ff @(posedge iVGA_CLK) begin
    if (push_s) begin
      mem_addr_r[wr_ptr_r] <= bus.iWR_ADDR;
      mem_data_r[wr_ptr_r] <= bus.iWR_DATA;
    end
  end

  // RAM port: scan address in SCAN, hold in GUARD, FIFO head while draining
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_wdata_r <= {DATA_W{1'b0}};
      ram_we_r    <= 1'b0;
    end else begin
      case (state_r)
        SCAN: begin
          ram_addr_r <= bus.iSCAN_ADDR;
          ram_we_r   <= 1'b0;
        end
        GUARD: begin
          ram_we_r <= 1'b0;
        end
        DRAIN: begin
          if (bus.iBLANK_n) begin
            // Active video resumes: hand the port straight back to scan-out.
            ram_addr_r <= bus.iSCAN_ADDR;
            ram_we_r   <= 1'b0;
          end else if (pop_s) begin
            ram_addr_r  <= mem_addr_r[rd_ptr_r];
            ram_wdata_r <= mem_data_r[rd_ptr_r];
            ram_we_r    <= 1'b1;
          end else begin
            ram_we_r <= 1'b0;
          end
        end
        default: begin
          ram_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oWR_READY   = ready_r;
  assign bus.oRAM_ADDR   = ram_addr_r;
  assign bus.oRAM_WDATA  = ram_wdata_r;
  assign bus.oRAM_WE     = ram_we_r;
  assign bus.oFIFO_LEVEL = level_r;

`ifdef FB_ARB_STALL_CNT_EN
  logic        vs_prev_r;
  logic [15:0] stall_r;

  // Stall counter: clears after a VS falling edge, otherwise saturating count
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      vs_prev_r <= 1'b1;
      stall_r   <= 16'd0;
    end else begin
      vs_prev_r <= bus.iVS;
      if (vs_prev_r && !bus.iVS) begin
        stall_r <= 16'd0;
      end else if (bus.iWR_VALID && !ready_r && (stall_r != 16'hFFFF)) begin
        stall_r <= stall_r + 16'd1;
      end else begin
        stall_r <= stall_r;
      end
    end
  end

  assign bus.oSTALL_CNT = stall_r;
`else
  assign bus.oSTALL_CNT = 16'd0;
`endif
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: scan pass-through, drain order and timing,
// full-FIFO back-pressure, short blank, mid-drain reset and the optional stall counter.
module tb_fb_write_arbiter;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  fb_write_arbiter_if #(.ADDR_W(19), .DATA_W(8), .FIFO_DEPTH(4)) bus ();

  fb_write_arbiter #(.ADDR_W(19), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .iVGA_CLK (clk),
    .iRST     (rst),
    .bus      (bus)
  );

`ifdef FB_ARB_STALL_CNT_EN
  localparam logic [15:0] STALL_HELD = 16'd6;
`else
  localparam logic [15:0] STALL_HELD = 16'd0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [18:0] a, input logic [7:0] d);
    bus.iWR_VALID = 1'b1;
    bus.iWR_ADDR  = a;
    bus.iWR_DATA  = d;
    tick();
    bus.iWR_VALID = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst            = 1'b1;
    bus.iBLANK_n   = 1'b1;
    bus.iVS        = 1'b1;
    bus.iSCAN_ADDR = 19'd0;
    bus.iWR_VALID  = 1'b0;
    bus.iWR_ADDR   = 19'd0;
    bus.iWR_DATA   = 8'd0;
    tick();
    tick();
    chk("rst_addr", bus.oRAM_ADDR, 32'd0);
    chk("rst_we", bus.oRAM_WE, 32'd0);
    chk("rst_ready", bus.oWR_READY, 32'd0);
    chk("rst_level", bus.oFIFO_LEVEL, 32'd0);
    chk("rst_stall", bus.oSTALL_CNT, 32'd0);

    // Scan pass-through, one cycle latency
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.iSCAN_ADDR = 19'(100 + i);
      tick();
      chk("scan_addr", bus.oRAM_ADDR, 32'(100 + i));
      chk("scan_we", bus.oRAM_WE, 32'd0);
    end
    chk("idle_ready", bus.oWR_READY, 32'd1);

    // Three writes, then blank: writes appear on cycles 2..4 after the first blank sample
    push(19'd5, 8'h11);
    push(19'd6, 8'h22);
    push(19'd7, 8'h33);
    chk("lvl3", bus.oFIFO_LEVEL, 32'd3);
    bus.iBLANK_n = 1'b0;
    tick();
    chk("blank_k0_we", bus.oRAM_WE, 32'd0);
    tick();
    chk("guard_we", bus.oRAM_WE, 32'd0);
    tick();
    chk("d1_we", bus.oRAM_WE, 32'd1);
    chk("d1_addr", bus.oRAM_ADDR, 32'd5);
    chk("d1_data", bus.oRAM_WDATA, 32'h11);
    chk("d1_lvl", bus.oFIFO_LEVEL, 32'd2);
    tick();
    chk("d2_we", bus.oRAM_WE, 32'd1);
    chk("d2_addr", bus.oRAM_ADDR, 32'd6);
    chk("d2_data", bus.oRAM_WDATA, 32'h22);
    tick();
    chk("d3_we", bus.oRAM_WE, 32'd1);
    chk("d3_addr", bus.oRAM_ADDR, 32'd7);
    chk("d3_data", bus.oRAM_WDATA, 32'h33);
    chk("d3_lvl", bus.oFIFO_LEVEL, 32'd0);
    tick();
    chk("empty_we", bus.oRAM_WE, 32'd0);
    chk("empty_addr_hold", bus.oRAM_ADDR, 32'd7);
    bus.iBLANK_n   = 1'b1;
    bus.iSCAN_ADDR = 19'd200;
    tick();
    chk("unblank_we", bus.oRAM_WE, 32'd0);
    bus.iSCAN_ADDR = 19'd201;
    tick();
    chk("rescan_addr", bus.oRAM_ADDR, 32'd201);

    // Fill the FIFO during active video; the fifth request is held
    for (int i = 0; i < 4; i++) push(19'(10 + i), 8'(8'hA0 + i));
    chk("full_ready", bus.oWR_READY, 32'd0);
    chk("full_lvl", bus.oFIFO_LEVEL, 32'd4);
    bus.iWR_VALID = 1'b1;
    bus.iWR_ADDR  = 19'd14;
    bus.iWR_DATA  = 8'hA4;
    tick();
    tick();
    tick();
    chk("held_lvl", bus.oFIFO_LEVEL, 32'd4);
    chk("held_ready", bus.oWR_READY, 32'd0);
    bus.iBLANK_n = 1'b0;
    tick();
    tick();
    tick();
    chk("f1_addr", bus.oRAM_ADDR, 32'd10);
    chk("f1_we", bus.oRAM_WE, 32'd1);
    chk("f1_lvl", bus.oFIFO_LEVEL, 32'd3);
    tick();
    bus.iWR_VALID = 1'b0;
    chk("f2_addr", bus.oRAM_ADDR, 32'd11);
    chk("f2_lvl", bus.oFIFO_LEVEL, 32'd3);
    tick();
    chk("f3_addr", bus.oRAM_ADDR, 32'd12);
    tick();
    chk("f4_addr", bus.oRAM_ADDR, 32'd13);
    chk("f4_data", bus.oRAM_WDATA, 32'hA3);
    tick();
    chk("f5_addr", bus.oRAM_ADDR, 32'd14);
    chk("f5_data", bus.oRAM_WDATA, 32'hA4);
    chk("f5_lvl", bus.oFIFO_LEVEL, 32'd0);
    tick();
    chk("f_empty_we", bus.oRAM_WE, 32'd0);
    chk("stall_held", bus.oSTALL_CNT, 32'(STALL_HELD));

    // One-cycle blank with two entries queued: no write
    bus.iBLANK_n = 1'b1;
    tick();
    push(19'd20, 8'h50);
    push(19'd21, 8'h51);
    bus.iBLANK_n = 1'b0;
    tick();
    chk("pulse_k0_we", bus.oRAM_WE, 32'd0);
    bus.iBLANK_n = 1'b1;
    tick();
    chk("pulse_guard_we", bus.oRAM_WE, 32'd0);
    tick();
    chk("pulse_after_we", bus.oRAM_WE, 32'd0);
    chk("pulse_lvl", bus.oFIFO_LEVEL, 32'd2);

    // Reset in the middle of a drain with three entries still pending
    push(19'd22, 8'h52);
    push(19'd23, 8'h53);
    bus.iBLANK_n = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_we", bus.oRAM_WE, 32'd1);
    chk("pre_rst_addr", bus.oRAM_ADDR, 32'd20);
    chk("pre_rst_lvl", bus.oFIFO_LEVEL, 32'd3);
    rst = 1'b1;
    tick();
    chk("mid_rst_addr", bus.oRAM_ADDR, 32'd0);
    chk("mid_rst_data", bus.oRAM_WDATA, 32'd0);
    chk("mid_rst_we", bus.oRAM_WE, 32'd0);
    chk("mid_rst_ready", bus.oWR_READY, 32'd0);
    chk("mid_rst_lvl", bus.oFIFO_LEVEL, 32'd0);
    chk("mid_rst_stall", bus.oSTALL_CNT, 32'd0);
    rst = 1'b0;
    bus.iSCAN_ADDR = 19'd300;
    tick();
    chk("post_rst_scan", bus.oRAM_ADDR, 32'd300);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_we", bus.oRAM_WE, 32'd0);
    end
    chk("post_rst_lvl", bus.oFIFO_LEVEL, 32'd0);

`ifdef FB_ARB_STALL_CNT_EN
    // Saturation and VS-falling-edge clear (clear wins over a stalled request)
    bus.iBLANK_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) push(19'(40 + i), 8'(i));
    bus.iWR_VALID = 1'b1;
    repeat (70000) tick();
    chk("stall_sat", bus.oSTALL_CNT, 32'hFFFF);
    bus.iVS = 1'b0;
    tick();
    chk("stall_clr", bus.oSTALL_CNT, 32'd0);
    tick();
    chk("stall_restart", bus.oSTALL_CNT, 32'd1);
    bus.iWR_VALID = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
